// File: rtl/dmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmd_pkg
// Description : Shared constants and capture-state encoding for the DMD
//               frame capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dmd_pkg;

  localparam int DMD_ROWS          = 32;
  localparam int DMD_COLS          = 128;
  localparam int DMD_BYTES_PER_ROW = DMD_COLS / 8;
  localparam int DMD_RAM_AW        = 10;
  localparam int DMD_ROW_AW        = 5;
  localparam int DMD_BYTE_AW       = 4;

  // Capture controller states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/dmd_frame_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : dmd_frame_capture_if
// Description : Row input, display read port and status bundle of the DMD
//               frame capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmd_frame_capture_if;
  import dmd_pkg::*;

  logic [DMD_COLS-1:0]                row_data;
  logic [DMD_ROW_AW-1:0]              row_addr;
  logic                               row_latch;
  logic [DMD_ROW_AW+DMD_BYTE_AW-1:0]  rd_addr;
  logic [7:0]                         rd_data;
  logic                               busy;
  logic                               frame_done;
  logic                               overrun;
  logic [15:0]                        frame_count;
  logic [7:0]                         drop_count;

  // Capture stage side
  modport slave (
    input  row_data, row_addr, row_latch, rd_addr,
    output rd_data, busy, frame_done, overrun, frame_count, drop_count
  );

  // Row receiver / panel driver side
  modport master (
    output row_data, row_addr, row_latch, rd_addr,
    input  rd_data, busy, frame_done, overrun, frame_count, drop_count
  );

endinterface
`default_nettype wire

// File: rtl/dmd_frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmd_frame_ram
// Description : Simple dual-port frame memory, synchronous write and
//               registered read on one clock. Address MSB selects the bank.
//               Contents are not reset; only the read register is.
// Revision    : 1.0 - initial release
// ============================================================================
module dmd_frame_ram
  import dmd_pkg::*;
#(
  parameter int AW = DMD_RAM_AW,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Write port
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/dmd_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : dmd_frame_capture
// Description : Synchronises the asynchronous row latch strobe, captures the
//               128-pixel row and writes it bytewise into a double-buffered
//               32x128 frame memory. Banks swap after the last row is written;
//               the display bank (~wr_bank) is read through a byte port.
//               Optional statistics counters under DMD_FRAME_CAPTURE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmd_frame_capture
  import dmd_pkg::*;
#(
  parameter int ROWS = DMD_ROWS,
  parameter int COLS = DMD_COLS
) (
  input  logic              clk,
  input  logic              rst,
  dmd_frame_capture_if.slave bus
);

  localparam logic [DMD_BYTE_AW-1:0] c_last_byte = DMD_BYTE_AW'(COLS / 8 - 1);
  localparam logic [DMD_ROW_AW-1:0]  c_last_row  = DMD_ROW_AW'(ROWS - 1);

  logic                   r_latch_s1, r_latch_s2, r_latch_s3;
  logic                   w_lat_ev;
  cap_state_t             r_state;
  logic [DMD_COLS-1:0]    r_cap_data;
  logic [DMD_ROW_AW-1:0]  r_cap_row;
  logic [DMD_BYTE_AW-1:0] r_byte_idx;
  logic                   r_wr_bank;
  logic                   r_busy;
  logic                   r_frame_done;
  logic                   r_overrun;
  logic                   w_we;
  logic                   w_drop_ev;
  logic                   w_swap;
  logic [7:0]             w_wdata;

  // Two-flop synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch_s1 <= 1'b0;
      r_latch_s2 <= 1'b0;
      r_latch_s3 <= 1'b0;
    end else begin
      r_latch_s1 <= bus.row_latch;
      r_latch_s2 <= r_latch_s1;
      r_latch_s3 <= r_latch_s2;
    end
  end

  assign w_lat_ev  = r_latch_s2 & ~r_latch_s3;
  assign w_we      = (r_state == WRITE);
  // A latch arriving while a row is still being written is lost
  assign w_drop_ev = w_we & w_lat_ev;
  assign w_swap    = w_we && (r_byte_idx == c_last_byte) && (r_cap_row == c_last_row);
  assign w_wdata   = r_cap_data[{r_byte_idx, 3'b000} +: 8];

  // Capture controller: accept a row in IDLE, stream its bytes out in WRITE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cap_data   <= '0;
      r_cap_row    <= '0;
      r_byte_idx   <= '0;
      r_wr_bank    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_drop_ev) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_lat_ev) begin
            r_cap_data <= bus.row_data;
            r_cap_row  <= bus.row_addr;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          r_byte_idx <= r_byte_idx + 1'b1;
          if (r_byte_idx == c_last_byte) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          if (w_swap) begin
            r_wr_bank    <= ~r_wr_bank;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  dmd_frame_ram #(
    .AW (DMD_RAM_AW),
    .DW (8)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr ({r_wr_bank, r_cap_row, r_byte_idx}),
    .wdata (w_wdata),
    .raddr ({~r_wr_bank, bus.rd_addr}),
    .rdata (bus.rd_data)
  );

  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;

`ifdef DMD_FRAME_CAPTURE_STATS_EN
  logic [15:0] r_frame_count;
  logic [7:0]  r_drop_count;

  // Completed-frame counter (wraps) and saturating dropped-latch counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_swap) r_frame_count <= r_frame_count + 16'd1;
      if (w_drop_ev && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign bus.frame_count = r_frame_count;
  assign bus.drop_count  = r_drop_count;
`else
  assign bus.frame_count = 16'd0;
  assign bus.drop_count  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmd_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmd_frame_capture
// Description : Self-checking bench for dmd_frame_capture. Reads are checked
//               by a scoreboard monitor; status outputs checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmd_frame_capture;
  import dmd_pkg::*;

`ifdef DMD_FRAME_CAPTURE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  localparam logic [127:0] ROW3 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] ROW5 = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_exp_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    rd_req = 1'b0;
  logic    rd_pend = 1'b0;
  rd_exp_t sb_q[$];
  int      total = 0;
  int      bad = 0;
  int      fd_cnt = 0;

  always #5 clk = ~clk;

  dmd_frame_capture_if bus();

  dmd_frame_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] fill(logic [7:0] b);
    return {16{b}};
  endfunction

  // Read response valid one cycle after the address is presented
  always @(posedge clk) rd_pend <= rd_req;

  // Monitor: count frame_done pulses, pop and compare read responses
  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got read data 0x%0h with nothing expected", bus.rd_data);
      end else begin
        e = sb_q.pop_front();
        check(e.name, {24'd0, bus.rd_data}, {24'd0, e.exp});
      end
    end
  end

  task automatic rd(input logic [4:0] row, input logic [3:0] byt, input logic [7:0] exp, input string name);
    @(negedge clk);
    bus.rd_addr = {row, byt};
    rd_req = 1'b1;
    sb_q.push_back('{name, exp});
  endtask

  task automatic rd_end();
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic latch_pulse(input logic [4:0] a, input logic [127:0] d);
    @(negedge clk);
    bus.row_addr  = a;
    bus.row_data  = d;
    bus.row_latch = 1'b1;
    repeat (3) @(negedge clk);
    bus.row_latch = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 64; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    if (bus.busy) begin
      total++;
      bad++;
      $display("FAIL %s: busy still 1 after 64 cycles, expected 0", name);
    end
  endtask

  // Latch one row and count the cycles busy is high
  task automatic send_row(input logic [4:0] a, input logic [127:0] d, output int bc);
    bit seen;
    seen = 1'b0;
    bc = 0;
    @(negedge clk);
    bus.row_addr  = a;
    bus.row_data  = d;
    bus.row_latch = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 2) bus.row_latch = 1'b0;
      if (bus.busy) begin
        seen = 1'b1;
        bc++;
      end else if (seen) begin
        break;
      end
    end
    bus.row_latch = 1'b0;
    if (!seen || bus.busy) begin
      total++;
      bad++;
      $display("FAIL send_row_timeout: row %0d seen=%0d busy=%0d, expected one busy window", a, seen, bus.busy);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  bc;
    bit  hit;
    bus.row_data  = '0;
    bus.row_addr  = '0;
    bus.row_latch = 1'b0;
    bus.rd_addr   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",        bus.busy,        0);
    check("rst_frame_done",  bus.frame_done,  0);
    check("rst_overrun",     bus.overrun,     0);
    check("rst_frame_count", bus.frame_count, 0);
    check("rst_drop_count",  bus.drop_count,  0);
    check("rst_rd_data",     bus.rd_data,     0);
    rst = 1'b0;
    fd_cnt = 0;

    // Full frame: rows 0..31, row 3 carries the reference pattern
    for (int r = 0; r < 32; r++) begin
      send_row(5'(r), (r == 3) ? ROW3 : fill(8'(r)), bc);
      if (r == 3)  check("busy_len_row3", bc, 16);
      if (r == 31) check("busy_len_row31", bc, 16);
      if (r == 30) check("no_swap_before_row31", fd_cnt, 0);
    end
    repeat (3) @(negedge clk);
    check("frame1_done_pulses", fd_cnt, 1);
    check("frame1_count", bus.frame_count, 1 * STATS);
    check("frame1_drop",  bus.drop_count, 0);
    check("frame1_overrun", bus.overrun, 0);
    rd(5'd3,  4'd0,  8'h77, "row3_b0");
    rd(5'd3,  4'd15, 8'h01, "row3_b15");
    rd(5'd3,  4'd8,  8'hEF, "row3_b8");
    rd(5'd3,  4'd4,  8'h33, "row3_b4");
    rd(5'd17, 4'd5,  8'h11, "row17_b5");
    rd(5'd0,  4'd0,  8'h00, "row0_b0");
    rd(5'd31, 4'd15, 8'h1F, "row31_b15");
    rd(5'd16, 4'd9,  8'h10, "row16_b9");
    rd_end();

    // Overrun: second latch 10 cycles after the first
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    fd_cnt = 0;
    latch_pulse(5'd5, ROW5);
    repeat (6) @(negedge clk);
    latch_pulse(5'd6, fill(8'hEE));
    wait_idle("ovr_idle");
    check("ovr_overrun", bus.overrun, 1);
    check("ovr_drop_count", bus.drop_count, 1 * STATS);
    send_row(5'd31, fill(8'hA5), bc);
    repeat (3) @(negedge clk);
    check("ovr_done_pulses", fd_cnt, 1);
    check("ovr_frame_count", bus.frame_count, 1 * STATS);
    rd(5'd5,  4'd0,  8'h0F, "row5_b0");
    rd(5'd5,  4'd7,  8'h78, "row5_b7");
    rd(5'd5,  4'd8,  8'h87, "row5_b8");
    rd(5'd5,  4'd15, 8'hF0, "row5_b15");
    rd(5'd6,  4'd0,  8'h06, "row6_untouched");
    rd(5'd31, 4'd0,  8'hA5, "row31_new");
    rd(5'd30, 4'd0,  8'h1E, "row30_old");
    rd_end();

    // Byte-15 collision: second latch edge lands in the byte-15 cycle
    send_row(5'd8, fill(8'h5A), bc);
    latch_pulse(5'd7, fill(8'h77));
    repeat (12) @(negedge clk);
    latch_pulse(5'd8, fill(8'hC3));
    repeat (6) @(negedge clk);
    check("coll_not_accepted", bus.busy, 0);
    check("coll_overrun", bus.overrun, 1);
    check("coll_drop_count", bus.drop_count, 2 * STATS);

    // Latch one cycle later than the collision case is accepted
    latch_pulse(5'd9, fill(8'h99));
    repeat (13) @(negedge clk);
    latch_pulse(5'd10, fill(8'hAA));
    check("spacing17_accepted", bus.busy, 1);
    wait_idle("spacing17_idle");
    check("spacing17_drop_count", bus.drop_count, 2 * STATS);
    send_row(5'd31, fill(8'h3C), bc);
    repeat (3) @(negedge clk);
    check("coll_done_pulses", fd_cnt, 2);
    check("coll_frame_count", bus.frame_count, 2 * STATS);
    rd(5'd7,  4'd0,  8'h77, "row7_b0");
    rd(5'd7,  4'd15, 8'h77, "row7_b15");
    rd(5'd8,  4'd3,  8'h5A, "row8_kept");
    rd(5'd9,  4'd0,  8'h99, "row9_b0");
    rd(5'd10, 4'd15, 8'hAA, "row10_b15");
    rd(5'd31, 4'd0,  8'h3C, "row31_bank1");
    rd_end();

    // Reset during byte 7 of row 31
    fd_cnt = 0;
    hit = 1'b0;
    bc = 0;
    @(negedge clk);
    bus.row_addr  = 5'd31;
    bus.row_data  = fill(8'h11);
    bus.row_latch = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 2) bus.row_latch = 1'b0;
      if (bus.busy) bc++;
      if (bc == 8) begin
        rst = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    bus.row_latch = 1'b0;
    check("midrst_reached_byte7", hit, 1);
    repeat (2) @(negedge clk);
    check("midrst_busy",        bus.busy,        0);
    check("midrst_overrun",     bus.overrun,     0);
    check("midrst_frame_count", bus.frame_count, 0);
    check("midrst_drop_count",  bus.drop_count,  0);
    check("midrst_rd_data",     bus.rd_data,     0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_frame_done", fd_cnt, 0);
    check("midrst_still_idle", bus.busy, 0);
    // wr_bank back at 0 means the display bank is bank 1 again
    rd(5'd7,  4'd0, 8'h77, "midrst_disp_row7");
    rd(5'd31, 4'd0, 8'h3C, "midrst_disp_row31");
    rd_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
